// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes encoder phases A/B, emits step/dir pulses and a wrapping count.
// Optional index reset of the count is built when QDEC_INDEX_EN is defined.
module quad_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             err_clr,
`ifdef QDEC_INDEX_EN
  input  logic             idx_in,
`endif
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int                 PRIME_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [1:0]             prev_q, prev_d;
  logic [1:0]             cur;
  logic [PRIME_W-1:0]     prime_cnt_q, prime_cnt_d;
  logic                   primed;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic                   fwd, bwd, illegal;

`ifdef QDEC_INDEX_EN
  logic [SYNC_STAGES-1:0] idx_sync_q, idx_sync_d;
  logic                   idx_prev_q, idx_prev_d;
  logic                   idx_rise;
`endif

  assign cur    = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign primed = (prime_cnt_q == PRIME_DONE);

  // Gray-code transition classification on {a,b}: forward is 00->10->11->01->00.
  always_comb begin
    fwd     = 1'b0;
    bwd     = 1'b0;
    illegal = 1'b0;
    case ({prev_q, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd     = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: bwd     = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_sync_d    = {a_sync_q[SYNC_STAGES-2:0], a_in};
    b_sync_d    = {b_sync_q[SYNC_STAGES-2:0], b_in};
    prev_d      = cur;
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + PRIME_W'(1);
    count_d     = count_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    err_d       = err_q;
`ifdef QDEC_INDEX_EN
    idx_sync_d  = {idx_sync_q[SYNC_STAGES-2:0], idx_in};
    idx_prev_d  = idx_sync_q[SYNC_STAGES-1];
    idx_rise    = primed & idx_sync_q[SYNC_STAGES-1] & ~idx_prev_q;
`endif

    if (primed) begin
      if (err_clr) err_d = 1'b0;
      if (fwd) begin
        count_d = count_q + WIDTH'(1);
        dir_d   = 1'b1;
        step_d  = 1'b1;
      end else if (bwd) begin
        count_d = count_q - WIDTH'(1);
        dir_d   = 1'b0;
        step_d  = 1'b1;
      end else if (illegal) begin
        err_d = 1'b1;
      end
`ifdef QDEC_INDEX_EN
      // Index edge zeroes the position but leaves the step/dir report intact.
      if (idx_rise) count_d = '0;
`endif
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_q    <= '0;
      b_sync_q    <= '0;
      prev_q      <= 2'b00;
      prime_cnt_q <= '0;
      count_q     <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef QDEC_INDEX_EN
      idx_sync_q  <= '0;
      idx_prev_q  <= 1'b0;
`endif
    end else begin
      a_sync_q    <= a_sync_d;
      b_sync_q    <= b_sync_d;
      prev_q      <= prev_d;
      prime_cnt_q <= prime_cnt_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
`ifdef QDEC_INDEX_EN
      idx_sync_q  <= idx_sync_d;
      idx_prev_q  <= idx_prev_d;
`endif
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (WIDTH=4, SYNC_STAGES=2).
module tb_quad_decoder;

  logic       clk;
  logic       rst_n;
  logic       a_in;
  logic       b_in;
  logic       err_clr;
  logic       idx_in;
  logic [3:0] count;
  logic       dir;
  logic       step;
  logic       err;

  int assert_count;
  int fail_count;

  quad_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_in    (a_in),
    .b_in    (b_in),
    .err_clr (err_clr),
`ifdef QDEC_INDEX_EN
    .idx_in  (idx_in),
`endif
    .count   (count),
    .dir     (dir),
    .step    (step),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; all drives and samples happen here.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic a, input logic b);
    rst_n   = 1'b0;
    a_in    = a;
    b_in    = b;
    err_clr = 1'b0;
    idx_in  = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] next_fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic test_reset();
    int pulses;
    do_reset(1'b1, 1'b1);
    assert_count++;
    if (count !== 4'd0 || err !== 1'b0 || dir !== 1'b0 || step !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_values: count=%0d dir=%b step=%b err=%b, required 0 0 0 0", count, dir, step, err);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (step !== 1'b0) pulses++;
    end
    assert_count++;
    if (pulses != 0 || count !== 4'd0 || err !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL prime_11: pulses=%0d count=%0d err=%b, required 0 0 0", pulses, count, err);
    end
  endtask

  task automatic test_forward();
    logic [1:0] st;
    do_reset(1'b0, 1'b0);
    tick(4);
    st = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      st = next_fwd(st);
      {a_in, b_in} = st;
      tick(2);
      assert_count++;
      if (step !== 1'b0) begin
        fail_count++;
        $display("[TB] FAIL fwd_early_%0d: step=%b, required 0", k, step);
      end
      tick(1);
      assert_count++;
      if (step !== 1'b1 || count !== 4'(k) || dir !== 1'b1) begin
        fail_count++;
        $display("[TB] FAIL fwd_step_%0d: step=%b count=%0d dir=%b, required 1 %0d 1", k, step, count, dir, k);
      end
      tick(1);
      assert_count++;
      if (step !== 1'b0) begin
        fail_count++;
        $display("[TB] FAIL fwd_pulse_len_%0d: step=%b, required 0", k, step);
      end
    end
  endtask

  task automatic test_backward_wrap();
    logic [1:0] st;
    int pulses;
    do_reset(1'b0, 1'b0);
    tick(4);
    {a_in, b_in} = 2'b01;
    tick(3);
    assert_count++;
    if (count !== 4'd15 || dir !== 1'b0 || step !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL back_wrap: count=%0d dir=%b step=%b, required 15 0 1", count, dir, step);
    end
    tick(1);
    st = 2'b01;
    pulses = 0;
    for (int k = 0; k < 17; k++) begin
      st = next_fwd(st);
      {a_in, b_in} = st;
      tick(1);
      if (step === 1'b1) pulses++;
      tick(1);
      if (step === 1'b1) pulses++;
    end
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (step === 1'b1) pulses++;
    end
    assert_count++;
    if (count !== 4'd0 || dir !== 1'b1 || pulses != 17) begin
      fail_count++;
      $display("[TB] FAIL fwd_wrap: count=%0d dir=%b pulses=%0d, required 0 1 17", count, dir, pulses);
    end
  endtask

  task automatic test_error();
    int pulses;
    do_reset(1'b0, 1'b0);
    tick(4);
    {a_in, b_in} = 2'b11;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (step === 1'b1) pulses++;
    end
    assert_count++;
    if (err !== 1'b1 || count !== 4'd0 || pulses != 0) begin
      fail_count++;
      $display("[TB] FAIL illegal_jump: err=%b count=%0d pulses=%0d, required 1 0 0", err, count, pulses);
    end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    assert_count++;
    if (err !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL err_clear: err=%b, required 0", err);
    end
    {a_in, b_in} = 2'b00;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    assert_count++;
    if (err !== 1'b1 || count !== 4'd0) begin
      fail_count++;
      $display("[TB] FAIL set_wins: err=%b count=%0d, required 1 0", err, count);
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] st;
    do_reset(1'b0, 1'b0);
    tick(4);
    st = 2'b00;
    for (int k = 0; k < 9; k++) begin
      st = next_fwd(st);
      {a_in, b_in} = st;
      tick(2);
    end
    {a_in, b_in} = 2'b01;
    tick(4);
    assert_count++;
    if (count !== 4'd9 || err !== 1'b1 || dir !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL pre_reset: count=%0d err=%b dir=%b, required 9 1 1", count, err, dir);
    end
    #1;
    rst_n = 1'b0;
    #1;
    assert_count++;
    if (count !== 4'd0 || err !== 1'b0 || dir !== 1'b0 || step !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL async_reset: count=%0d err=%b dir=%b step=%b, required 0 0 0 0", count, err, dir, step);
    end
    tick(1);
    rst_n = 1'b1;
  endtask

`ifdef QDEC_INDEX_EN
  task automatic test_index();
    logic [1:0] st;
    do_reset(1'b0, 1'b0);
    tick(4);
    st = 2'b00;
    for (int k = 0; k < 7; k++) begin
      st = next_fwd(st);
      {a_in, b_in} = st;
      tick(2);
    end
    tick(2);
    assert_count++;
    if (count !== 4'd7) begin
      fail_count++;
      $display("[TB] FAIL idx_pre: count=%0d, required 7", count);
    end
    st = next_fwd(st);
    {a_in, b_in} = st;
    idx_in = 1'b1;
    tick(3);
    assert_count++;
    if (count !== 4'd0 || step !== 1'b1 || dir !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL idx_zero: count=%0d step=%b dir=%b, required 0 1 1", count, step, dir);
    end
    for (int k = 1; k <= 2; k++) begin
      st = next_fwd(st);
      {a_in, b_in} = st;
      tick(3);
      assert_count++;
      if (count !== 4'(k) || step !== 1'b1) begin
        fail_count++;
        $display("[TB] FAIL idx_held_%0d: count=%0d step=%b, required %0d 1", k, count, step, k);
      end
    end
  endtask
`endif

  initial begin
    assert_count = 0;
    fail_count   = 0;
    rst_n   = 1'b0;
    a_in    = 1'b0;
    b_in    = 1'b0;
    err_clr = 1'b0;
    idx_in  = 1'b0;
    test_reset();
    test_forward();
    test_backward_wrap();
    test_error();
    test_async_reset();
`ifdef QDEC_INDEX_EN
    test_index();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder that turns two phase-shifted inputs (A/B) into signed step events and a wrapping position count. It is the counterpart of the team's 4-bit up/down counter: the counter consumes an up/down select, while this block derives direction from an external encoder and produces the count. It sits at the chip boundary and feeds position and step events to control logic.

## Interface
- WIDTH, 4, width of position count; count wraps modulo 2^WIDTH
- SYNC_STAGES, 2, flip-flop depth of input synchronizers (>= 2)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- a_in  in  1  encoder phase A, asynchronous to clk
- b_in  in  1  encoder phase B, asynchronous to clk
- err_clr  in  1  synchronous clear of sticky error flag
- idx_in  in  1  encoder index pulse, asynchronous; present only with QDEC_INDEX_EN
- count  out  WIDTH  current position
- dir  out  1  direction of last valid step: 1 forward, 0 backward
- step  out  1  one-cycle pulse per valid step
- err  out  1  sticky illegal-transition flag

## Operation
- a_in and b_in each pass through SYNC_STAGES flops, all reset to 0. Decode uses the final-stage pair s = {a,b} and a registered previous pair p.
- Prime phase: for the first SYNC_STAGES+1 rising edges after reset release, p loads s with no decode, so no step and no err, whatever the input levels are.
- After priming, every edge compares p to s, then loads p <= s:
  - s == p: idle; step = 0, and count, dir, and err hold.
  - Forward (00->10, 10->11, 11->01, 01->00): count <= count + 1, dir <= 1, step <= 1.
  - Backward (00->01, 01->11, 11->10, 10->00): count <= count - 1, dir <= 0, step <= 1.
  - Illegal (both bits change): err <= 1, step = 0, count and dir hold; p still takes the new value.
- Count arithmetic is unsigned modulo 2^WIDTH. With WIDTH=4: 15 + 1 -> 0, 0 - 1 -> 15.
- err stays set until err_clr is sampled high. If err_clr and an illegal transition occur on the same edge, err ends at 1 (set wins).
- Reset values: count = 0, dir = 0, step = 0, err = 0, synchronizers = 0, p = 00, prime counter restarts.
- Reset asserted mid-operation clears all state immediately (asynchronously); priming repeats after release.

## Timing
- Latency: a level change on a_in/b_in first captured at edge N updates count/dir/step/err at edge N+SYNC_STAGES (3 edges total at default).
- step is high for exactly one cycle per valid transition, so back-to-back transitions on consecutive cycles give consecutive step pulses.
- Max input rate: one A/B edge per clk cycle at the synchronizer output. Faster inputs produce illegal transitions, which are flagged via err.
- err_clr takes effect on the edge at which it is sampled high; err reads 0 the following cycle unless the set condition also holds.
- No handshake: outputs are registered and valid every cycle after reset.

## Configuration
- QDEC_INDEX_EN defined:
  - idx_in exists and is synchronized with SYNC_STAGES flops.
  - A 0->1 edge of the synchronized index (detected after priming) sets count <= 0 on that edge, overriding any same-edge step.
  - step and dir still update normally for a coincident valid transition.
  - Index edges during priming are ignored.
- QDEC_INDEX_EN undefined: the idx_in port and all index logic are absent; count changes only by steps and reset.

## Test plan
- Reset with a_in=1, b_in=1 held, then release and wait 10 cycles -> count=0, step never pulses, err=0 (priming absorbs initial 11).
- After priming from 00, apply 00->10->11->01->00 with 4 cycles per state -> 4 step pulses, dir=1, count=4; each update lands exactly 3 edges after the input change.
- From count=0, apply one backward transition 00->01 -> count=15, dir=0, one step pulse. Then drive 17 forward transitions -> count=0 (wrap).
- Jump 00->11 -> err=1, count unchanged, no step. Pulse err_clr -> err=0 next cycle. Then err_clr coincident with another 11->00 jump -> err stays 1.
- Assert rst_n low while count=9 and err=1 -> count=0, err=0, dir=0, step=0 immediately, without waiting for a clock edge.
- With QDEC_INDEX_EN: count=7, idx_in rises on the same sampled edge as a forward transition -> count=0, step=1, dir=1. With idx_in held high, further forward steps count 1, 2, ...
